// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - access size encodings (log2 of the byte count)
//   - response error codes returned to WBU
//   - FSM state encoding
//   - byte-enable mask helper for a given access size
package lsu_pkg;

    // Access size: log2 of the number of bytes moved.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Result status reported alongside rsp_rdata.
    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_MISAL = 2'd1;
    localparam logic [1:0] ERR_BUS   = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        MISAL,
        BUSREQ,
        BUSWAIT,
        RESP
    } lsu_state_e;

    // Unshifted byte-enable mask for an access of the given size
    // (bit 0 = lowest byte of the access).
    function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
        logic [7:0] mask;
        unique case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage : lsu_pkg

// File: rtl/lsu_load_align.sv
// Purely combinational read-data alignment for the load/store unit.
// Shifts the full bus word down to the addressed byte lane, keeps the
// bytes covered by the access size and sign- or zero-extends to XLEN.
//
// Ports:
//   bus_rdata  in  BUS_W  full bus word returned by memory
//   off        in  OFF_W  byte offset of the access within the bus word
//   size       in  2      log2 access bytes (SZ_B..SZ_D)
//   sext       in  1      1 = sign-extend, 0 = zero-extend
//   load_data  out XLEN   aligned and extended load result
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int BUS_W = 64,
    parameter int OFF_W = $clog2(BUS_W / 8)
) (
    input  logic [BUS_W-1:0] bus_rdata,
    input  logic [OFF_W-1:0] off,
    input  logic [1:0]       size,
    input  logic             sext,
    output logic [XLEN-1:0]  load_data
);

    logic [BUS_W-1:0] shifted;
    logic [XLEN-1:0]  raw;
    logic [XLEN-1:0]  keep;
    logic             sign;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        shifted = bus_rdata >> {off, 3'b000};
        raw     = XLEN'(shifted);
        keep    = '1;
        sign    = raw[XLEN-1];
        unique case (size)
            SZ_B: begin
                keep = XLEN'(64'h0000_0000_0000_00FF);
                sign = raw[7];
            end
            SZ_H: begin
                keep = XLEN'(64'h0000_0000_0000_FFFF);
                sign = raw[15];
            end
            SZ_W: begin
                keep = XLEN'(64'h0000_0000_FFFF_FFFF);
                sign = raw[31];
            end
            default: begin
                // Doubleword: all XLEN bits kept, so extension is a pass-through.
                keep = '1;
                sign = raw[XLEN-1];
            end
        endcase
        load_data = (sext && sign) ? (raw | ~keep) : (raw & keep);
    end

endmodule : lsu_load_align

// File: rtl/lsu_unit.sv
// Handshaked load/store unit between EXU and the data-memory bus.
// One transaction at a time: accept from EXU, build a lane-aligned bus
// request (or flag a misaligned access without touching the bus), wait for
// the bus response, extract/extend read data and hand the result to WBU.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    EXU request (valid/ready, wen, addr, wdata, size, sext)
//   bus_req_*                bus request (valid/ready, wen, aligned addr, wdata, wmask)
//   bus_rsp_*                bus response (valid/ready, rdata, err)
//   rsp_*                    WBU result (valid/ready, rdata, err code)
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int BUS_W  = 64,
    parameter int ADDR_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wen,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [1:0]           req_size,
    input  logic                 req_sext,

    output logic                 bus_req_valid,
    input  logic                 bus_req_ready,
    output logic                 bus_req_wen,
    output logic [ADDR_W-1:0]    bus_req_addr,
    output logic [BUS_W-1:0]     bus_req_wdata,
    output logic [BUS_W/8-1:0]   bus_req_wmask,

    input  logic                 bus_rsp_valid,
    output logic                 bus_rsp_ready,
    input  logic [BUS_W-1:0]     bus_rsp_rdata,
    input  logic                 bus_rsp_err,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [XLEN-1:0]      rsp_rdata,
    output logic [1:0]           rsp_err
);

    localparam int NB    = BUS_W / 8;
    localparam int OFF_W = $clog2(NB);
    // Doubleword accesses need both a 64-bit register file and a 64-bit bus.
    localparam bit DW_OK = (XLEN == 64) && (BUS_W == 64);

    lsu_state_e state, state_nxt;

    // Captured request.
    logic              cap_wen;
    logic [ADDR_W-1:0] cap_addr;
    logic [XLEN-1:0]   cap_wdata;
    logic [1:0]        cap_size;
    logic              cap_sext;

    // Registered result presented in RESP.
    logic [XLEN-1:0]   rsp_data_q;
    logic [1:0]        rsp_err_q;

    // ------------------------------------------------------------------
    // Request-side misalignment check (evaluated on the incoming request)
    // ------------------------------------------------------------------
    logic [2:0] align_mask;
    logic       req_misal;

    always_comb begin
        align_mask = 3'b000;
        unique case (req_size)
            SZ_B:    align_mask = 3'b000;
            SZ_H:    align_mask = 3'b001;
            SZ_W:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        req_misal = (|(req_addr[2:0] & align_mask)) || ((req_size == SZ_D) && !DW_OK);
    end

    // ------------------------------------------------------------------
    // Lane computation from the captured request
    // ------------------------------------------------------------------
    logic [OFF_W-1:0]  cap_off;
    logic [NB-1:0]     lane_mask;
    logic [BUS_W-1:0]  lane_wdata;
    logic [ADDR_W-1:0] lane_addr;
    logic [XLEN-1:0]   load_data;

    assign cap_off    = cap_addr[OFF_W-1:0];
    assign lane_mask  = NB'(size_byte_mask(cap_size)) << cap_off;
    assign lane_wdata = BUS_W'(cap_wdata) << {cap_off, 3'b000};
    assign lane_addr  = cap_addr & ~ADDR_W'(NB - 1);

    lsu_load_align #(
        .XLEN  (XLEN),
        .BUS_W (BUS_W),
        .OFF_W (OFF_W)
    ) u_load_align (
        .bus_rdata (bus_rsp_rdata),
        .off       (cap_off),
        .size      (cap_size),
        .sext      (cap_sext),
        .load_data (load_data)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples values from before the clock edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_valid)     state_nxt = req_misal ? MISAL : BUSREQ;
            MISAL:                      state_nxt = RESP;
            BUSREQ:  if (bus_req_ready) state_nxt = BUSWAIT;
            BUSWAIT: if (bus_rsp_valid) state_nxt = RESP;
            RESP:    if (rsp_ready)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (all driven from state and registered data only)
    // ------------------------------------------------------------------
    always_comb begin
        req_ready     = 1'b0;
        bus_req_valid = 1'b0;
        bus_req_wen   = 1'b0;
        bus_req_addr  = '0;
        bus_req_wdata = '0;
        bus_req_wmask = '0;
        bus_rsp_ready = 1'b0;
        rsp_valid     = 1'b0;
        rsp_rdata     = '0;
        rsp_err       = ERR_OK;
        unique case (state)
            IDLE: req_ready = 1'b1;
            BUSREQ: begin
                bus_req_valid = 1'b1;
                bus_req_wen   = cap_wen;
                bus_req_addr  = lane_addr;
                // Loads present no write lanes at all.
                if (cap_wen) begin
                    bus_req_wdata = lane_wdata;
                    bus_req_wmask = lane_mask;
                end
            end
            BUSWAIT: bus_rsp_ready = 1'b1;
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rsp_data_q;
                rsp_err   = rsp_err_q;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: the capture and result registers are plain flops, not a memory
    // array, so they are all cleared by reset and nothing stale leaks out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_wen    <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_size   <= SZ_B;
            cap_sext   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= ERR_OK;
        end else begin
            if ((state == IDLE) && req_valid) begin
                cap_wen   <= req_wen;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_size  <= req_size;
                cap_sext  <= req_sext;
            end
            if (state == MISAL) begin
                rsp_data_q <= '0;
                rsp_err_q  <= ERR_MISAL;
            end
            if ((state == BUSWAIT) && bus_rsp_valid) begin
                // Stores and failed accesses return zero data.
                rsp_data_q <= (bus_rsp_err || cap_wen) ? '0 : load_data;
                rsp_err_q  <= bus_rsp_err ? ERR_BUS : ERR_OK;
            end
        end
    end

endmodule : lsu_unit

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit (XLEN=BUS_W=ADDR_W=64) and a standalone
// exercise of lsu_load_align, both compared against a reference model.
module tb_lsu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_sext;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        bus_req_valid, bus_req_ready, bus_req_wen;
    logic [63:0] bus_req_addr, bus_req_wdata;
    logic [7:0]  bus_req_wmask;
    logic        bus_rsp_valid, bus_rsp_ready, bus_rsp_err;
    logic [63:0] bus_rsp_rdata;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_err;

    // Standalone aligner stimulus.
    logic [63:0] al_rdata, al_data;
    logic [2:0]  al_off;
    logic [1:0]  al_size;
    logic        al_sext;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lsu_unit #(.XLEN(64), .BUS_W(64), .ADDR_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wen       (req_wen),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_size      (req_size),
        .req_sext      (req_sext),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_wen   (bus_req_wen),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wdata (bus_req_wdata),
        .bus_req_wmask (bus_req_wmask),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_ready (bus_rsp_ready),
        .bus_rsp_rdata (bus_rsp_rdata),
        .bus_rsp_err   (bus_rsp_err),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err)
    );

    lsu_load_align #(.XLEN(64), .BUS_W(64), .OFF_W(3)) u_align (
        .bus_rdata (al_rdata),
        .off       (al_off),
        .size      (al_size),
        .sext      (al_sext),
        .load_data (al_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    endtask

    // One cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference load extraction: take 8<<size bits starting at byte off, then extend.
    function automatic logic [63:0] load_model(input logic [63:0] word, input int off,
                                               input int size, input logic sext);
        int          nbits;
        logic [63:0] v;
        logic [63:0] keep;
        nbits = 8 << size;
        v     = word >> (off * 8);
        keep  = (nbits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbits) - 64'd1);
        v     = v & keep;
        if (sext && v[nbits-1]) v = v | ~keep;
        return v;
    endfunction

    // Full transaction with configurable stalls on the bus request, the bus
    // response and the WBU side.
    task automatic do_txn(input string name, input logic wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [1:0] size, input logic sext,
                          input logic [63:0] word, input logic berr,
                          input int req_stall, input int rsp_stall, input int wb_stall);
        int          off, nbytes, m;
        bit          misal;
        logic [63:0] e_addr, e_wdata, e_rdata;
        logic [7:0]  e_mask;
        logic [1:0]  e_err;

        off    = int'(addr[2:0]);
        nbytes = 1 << size;
        misal  = (addr % 64'(nbytes)) != 0;
        m      = ((1 << nbytes) - 1) << off;
        e_addr  = addr & ~64'h7;
        e_mask  = wen ? m[7:0] : 8'h00;
        e_wdata = wen ? (wdata << (off * 8)) : 64'h0;
        if (misal) begin
            e_err = 2'd1; e_rdata = 64'h0;
        end else if (berr) begin
            e_err = 2'd2; e_rdata = 64'h0;
        end else begin
            e_err   = 2'd0;
            e_rdata = wen ? 64'h0 : load_model(word, off, int'(size), sext);
        end

        check({name, ".req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_wen = wen; req_addr = addr;
        req_wdata = wdata; req_size = size; req_sext = sext;
        tick();
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};

        if (misal) begin
            check({name, ".misal_no_bus"}, 64'(bus_req_valid), 64'd0);
            check({name, ".misal_rsp_early"}, 64'(rsp_valid), 64'd0);
            tick();
            check({name, ".misal_no_bus2"}, 64'(bus_req_valid), 64'd0);
        end else begin
            check({name, ".bus_valid"}, 64'(bus_req_valid), 64'd1);
            for (int i = 0; i <= req_stall; i++) begin
                check({name, ".bus_addr"}, bus_req_addr, e_addr);
                check({name, ".bus_wen"}, 64'(bus_req_wen), 64'(wen));
                check({name, ".bus_wmask"}, 64'(bus_req_wmask), 64'(e_mask));
                check({name, ".bus_wdata"}, bus_req_wdata, e_wdata);
                check({name, ".req_ready_busy"}, 64'(req_ready), 64'd0);
                if (i < req_stall) begin
                    tick();
                    check({name, ".bus_valid_held"}, 64'(bus_req_valid), 64'd1);
                end
            end
            bus_req_ready = 1'b1;
            tick();
            bus_req_ready = 1'b0;
            check({name, ".bus_valid_drop"}, 64'(bus_req_valid), 64'd0);
            check({name, ".rsp_ready_bus"}, 64'(bus_rsp_ready), 64'd1);
            for (int i = 0; i < rsp_stall; i++) begin
                tick();
                check({name, ".rsp_wait"}, 64'(rsp_valid), 64'd0);
            end
            bus_rsp_valid = 1'b1; bus_rsp_rdata = word; bus_rsp_err = berr;
            tick();
            bus_rsp_valid = 1'b0; bus_rsp_rdata = {$urandom, $urandom}; bus_rsp_err = 1'b0;
        end

        check({name, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
        for (int i = 0; i < wb_stall; i++) begin
            check({name, ".rsp_rdata_held"}, rsp_rdata, e_rdata);
            check({name, ".rsp_err_held"}, 64'(rsp_err), 64'(e_err));
            check({name, ".req_ready_resp"}, 64'(req_ready), 64'd0);
            tick();
            check({name, ".rsp_valid_held"}, 64'(rsp_valid), 64'd1);
        end
        check({name, ".rsp_rdata"}, rsp_rdata, e_rdata);
        check({name, ".rsp_err"}, 64'(rsp_err), 64'(e_err));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({name, ".rsp_done"}, 64'(rsp_valid), 64'd0);
        check({name, ".req_ready_back"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_sext = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0; bus_rsp_err = 1'b0;
        rsp_ready = 1'b0;
        al_rdata = '0; al_off = '0; al_size = '0; al_sext = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("reset.req_ready", 64'(req_ready), 64'd1);
        check("reset.bus_req_valid", 64'(bus_req_valid), 64'd0);
        check("reset.bus_req_addr", bus_req_addr, 64'd0);
        check("reset.bus_rsp_ready", 64'(bus_rsp_ready), 64'd0);
        check("reset.rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset.rsp_err", 64'(rsp_err), 64'd0);

        // Directed cases.
        do_txn("lb_sext", 1'b0, 64'h8000_0005, 64'h0, 2'd0, 1'b1,
               64'h1122_8044_AABB_CCDD, 1'b0, 0, 0, 0);
        do_txn("sh", 1'b1, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 2'd1, 1'b0,
               64'h0, 1'b0, 0, 0, 0);
        do_txn("misal_w", 1'b0, 64'h8000_0002, 64'h0, 2'd2, 1'b0,
               64'h0, 1'b0, 0, 0, 0);
        do_txn("backpressure", 1'b0, 64'h8000_0008, 64'h0, 2'd3, 1'b0,
               64'h0123_4567_89AB_CDEF, 1'b0, 3, 1, 2);
        do_txn("bus_err", 1'b0, 64'h8000_0010, 64'h0, 2'd3, 1'b1,
               64'hFFFF_0000_FFFF_0000, 1'b1, 0, 0, 0);

        // Reset while waiting for the bus response, then a stale response.
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0020;
        req_size = 2'd2; req_sext = 1'b1;
        tick();
        req_valid = 1'b0;
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        check("rstmid.in_wait", 64'(bus_rsp_ready), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid.req_ready", 64'(req_ready), 64'd1);
        check("rstmid.bus_rsp_ready", 64'(bus_rsp_ready), 64'd0);
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        bus_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstmid.no_rsp", 64'(rsp_valid), 64'd0);
            check("rstmid.idle", 64'(req_ready), 64'd1);
            tick();
        end
        do_txn("lw_after_rst", 1'b0, 64'h8000_0014, 64'h0, 2'd2, 1'b0,
               64'h8000_0001_1234_5678, 1'b0, 0, 0, 0);

        // Randomised transactions.
        for (int t = 0; t < 60; t++) begin
            logic [1:0]  sz;
            logic [63:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = 64'h8000_0000 + 64'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            do_txn("rand", 1'($urandom), a, {$urandom, $urandom}, sz, 1'($urandom),
                   {$urandom, $urandom}, ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Standalone aligner vectors.
        for (int t = 0; t < 40; t++) begin
            al_rdata = {$urandom, $urandom};
            al_size  = 2'($urandom_range(0, 3));
            al_off   = 3'($urandom_range(0, 7)) & ~3'((1 << al_size) - 1);
            al_sext  = 1'($urandom);
            #1;
            check("align", al_data, load_model(al_rdata, int'(al_off), int'(al_size), al_sext));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_lsu_unit
